// File: rtl/acc_tdm.sv
// Time-multiplexed signed accumulator: NCH channels share one adder/subtractor.
// Optional clamp on signed overflow, sticky overflow flag, registered tagged output.
module acc_tdm #(
  parameter int W   = 12,
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int SAT = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           sclr_i,
  input  logic           in_vld_i,
  input  logic           ch_sync_i,
  input  logic           acc_i,
  input  logic           sub_i,
  input  logic [W-1:0]   b_i,
  output logic [W-1:0]   q_o,
  output logic           co_o,
  output logic           ov_o,
  output logic           ovs_o,
  output logic           out_vld_o,
  output logic [CHW-1:0] out_ch_o
);

  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
  localparam logic [W-1:0]   POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   NEG_MIN = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0]   m_q [NCH];
  logic [W-1:0]   m_d;
  logic [CHW-1:0] ptr_q, ptr_d;

  logic [W-1:0]   q_q, q_d;
  logic           co_q, co_d;
  logic           ov_q, ov_d;
  logic           ovs_q, ovs_d;
  logic           vld_q, vld_d;
  logic [CHW-1:0] och_q, och_d;

  logic [CHW-1:0] ch_sel;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W:0]     sum;
  logic           carry_msb_in;
  logic           ovf;
  logic           sat_neg;

  // CH_SYNC realigns the round-robin to channel 0 for this sample.
  assign ch_sel = ch_sync_i ? '0 : ptr_q;

  // Read of the stored value is combinational so back-to-back samples see the update.
  assign op_a = acc_i ? m_q[ch_sel] : '0;
  assign op_b = sub_i ? ~b_i : b_i;
  assign sum  = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, sub_i};

  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  assign carry_msb_in = sum[W-1] ^ op_a[W-1] ^ op_b[W-1];
  assign ovf          = carry_msb_in ^ sum[W];

  // On overflow both operands share a sign; with ACC=0 A is zero, so use B'.
  assign sat_neg = acc_i ? op_a[W-1] : op_b[W-1];

  always_comb begin
    m_d = sum[W-1:0];
    if ((SAT != 0) && ovf) begin
      m_d = sat_neg ? NEG_MIN : POS_MAX;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (in_vld_i) begin
      ptr_d = (ch_sel == LAST_CH) ? '0 : ch_sel + CHW'(1);
    end
  end

  always_comb begin
    q_d   = q_q;
    co_d  = co_q;
    ov_d  = ov_q;
    ovs_d = ovs_q;
    vld_d = 1'b0;
    och_d = och_q;
    if (sclr_i) begin
      q_d   = '0;
      co_d  = 1'b0;
      ov_d  = 1'b0;
      ovs_d = 1'b0;
      och_d = '0;
    end else if (in_vld_i) begin
      q_d   = m_d;
      co_d  = sum[W];
      ov_d  = ovf;
      ovs_d = ovs_q | ovf;
      vld_d = 1'b1;
      och_d = ch_sel;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        m_q[i] <= '0;
      end
    end else if (sclr_i) begin
      for (int i = 0; i < NCH; i++) begin
        m_q[i] <= '0;
      end
    end else if (in_vld_i) begin
      m_q[ch_sel] <= m_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (sclr_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q   <= '0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
      ovs_q <= 1'b0;
      vld_q <= 1'b0;
      och_q <= '0;
    end else begin
      q_q   <= q_d;
      co_q  <= co_d;
      ov_q  <= ov_d;
      ovs_q <= ovs_d;
      vld_q <= vld_d;
      och_q <= och_d;
    end
  end

  assign q_o       = q_q;
  assign co_o      = co_q;
  assign ov_o      = ov_q;
  assign ovs_o     = ovs_q;
  assign out_vld_o = vld_q;
  assign out_ch_o  = och_q;

endmodule

// File: tb/tb_acc_tdm.sv
// Bench for acc_tdm: wrapping (SAT=0) and clamping (SAT=1) instances share stimulus
// and are checked every cycle against an integer model, plus directed literal checks.
module tb_acc_tdm;

  localparam int W    = 12;
  localparam int NCH  = 4;
  localparam int CHW  = 2;
  localparam int MASK = (1 << W) - 1;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclr = 1'b0, in_vld = 1'b0, ch_sync = 1'b0, acc = 1'b0, sub = 1'b0;
  logic [W-1:0] b = '0;

  logic [W-1:0]   q_w   [2];
  logic           co_w  [2];
  logic           ov_w  [2];
  logic           ovs_w [2];
  logic           vld_w [2];
  logic [CHW-1:0] och_w [2];

  int n_pass = 0;
  int n_total = 0;
  bit started = 0;

  always #5 clk = ~clk;

  acc_tdm #(.W(W), .NCH(NCH), .CHW(CHW), .SAT(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .sclr_i(sclr), .in_vld_i(in_vld), .ch_sync_i(ch_sync),
    .acc_i(acc), .sub_i(sub), .b_i(b), .q_o(q_w[0]), .co_o(co_w[0]), .ov_o(ov_w[0]),
    .ovs_o(ovs_w[0]), .out_vld_o(vld_w[0]), .out_ch_o(och_w[0]));

  acc_tdm #(.W(W), .NCH(NCH), .CHW(CHW), .SAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .sclr_i(sclr), .in_vld_i(in_vld), .ch_sync_i(ch_sync),
    .acc_i(acc), .sub_i(sub), .b_i(b), .q_o(q_w[1]), .co_o(co_w[1]), .ov_o(ov_w[1]),
    .ovs_o(ovs_w[1]), .out_vld_o(vld_w[1]), .out_ch_o(och_w[1]));

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int sx(input int v);
    return ((v & (1 << (W - 1))) != 0) ? (v | ~MASK) : (v & MASK);
  endfunction

  // Model: channel contents as true signed integers, one set per instance.
  int  mm [2][NCH];
  int  ptr;
  int  e_q [2], e_co [2], e_ov [2], e_ovs [2];
  int  e_vld, e_och;
  bit  och_known;
  int  mc, ma, mb, mr, mst, mraw;
  bit  movf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr = 0; e_vld = 0; e_och = 0; och_known = 1;
      for (int d = 0; d < 2; d++) begin
        e_q[d] = 0; e_co[d] = 0; e_ov[d] = 0; e_ovs[d] = 0;
        for (int i = 0; i < NCH; i++) mm[d][i] = 0;
      end
    end else if (sclr) begin
      ptr = 0; e_vld = 0; och_known = 0;
      for (int d = 0; d < 2; d++) begin
        e_q[d] = 0; e_co[d] = 0; e_ov[d] = 0; e_ovs[d] = 0;
        for (int i = 0; i < NCH; i++) mm[d][i] = 0;
      end
    end else if (in_vld) begin
      mc = ch_sync ? 0 : ptr;
      mb = sx(int'(b));
      for (int d = 0; d < 2; d++) begin
        ma   = acc ? mm[d][mc] : 0;
        mr   = ma + (sub ? -mb : mb);
        movf = (mr > MAXV) || (mr < MINV);
        mraw = (ma & MASK) + (sub ? (~int'(b) & MASK) : int'(b)) + (sub ? 1 : 0);
        if (d == 1 && movf) mst = (mr > 0) ? MAXV : MINV;
        else mst = sx(mr & MASK);
        mm[d][mc] = mst;
        e_q[d]    = mst & MASK;
        e_co[d]   = (mraw >> W) & 1;
        e_ov[d]   = movf ? 1 : 0;
        e_ovs[d]  = e_ovs[d] | (movf ? 1 : 0);
      end
      ptr = (mc == NCH - 1) ? 0 : mc + 1;
      e_vld = 1; e_och = mc; och_known = 1;
    end else begin
      e_vld = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("cmp_q%0d", d),   int'(q_w[d]),   e_q[d]);
        chk($sformatf("cmp_co%0d", d),  int'(co_w[d]),  e_co[d]);
        chk($sformatf("cmp_ov%0d", d),  int'(ov_w[d]),  e_ov[d]);
        chk($sformatf("cmp_ovs%0d", d), int'(ovs_w[d]), e_ovs[d]);
        chk($sformatf("cmp_vld%0d", d), int'(vld_w[d]), e_vld);
        if (och_known) chk($sformatf("cmp_och%0d", d), int'(och_w[d]), e_och);
      end
    end
  end

  task automatic step(input bit v, input bit s, input bit a, input bit sb, input int bb,
                      input bit cl = 1'b0);
    logic [31:0] bv;
    bv = bb;
    in_vld = v; ch_sync = s; acc = a; sub = sb; b = bv[W-1:0]; sclr = cl;
    @(posedge clk); #2;
    in_vld = 0; ch_sync = 0; sclr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    started = 1;

    // 1: plain load and hold
    step(1, 0, 0, 0, 'h123);
    chk("t1_q", int'(q_w[0]), 'h123);
    chk("t1_vld", int'(vld_w[0]), 1);
    chk("t1_och", int'(och_w[0]), 0);
    chk("t1_co_ov", int'({co_w[0], ov_w[0]}), 0);
    idle(1);
    chk("t1_idle_vld", int'(vld_w[0]), 0);
    chk("t1_idle_q", int'(q_w[0]), 'h123);

    // 2: per-channel accumulate and pointer wrap
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 2);
    step(1, 0, 0, 0, 3);
    step(1, 0, 0, 0, 4);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0, 'h010);
      chk($sformatf("t2_q%0d", i), int'(q_w[0]), 'h011 + i);
      chk($sformatf("t2_och%0d", i), int'(och_w[0]), i);
    end
    step(1, 0, 1, 1, 1);
    chk("t2_sub_q", int'(q_w[0]), 'h010);
    chk("t2_sub_och", int'(och_w[0]), 0);

    // 3: negation, carry-out, most-negative negate
    step(1, 0, 0, 1, 'h001);
    chk("t3_neg1_q", int'(q_w[0]), 'hFFF);
    chk("t3_neg1_co", int'(co_w[0]), 0);
    step(1, 0, 0, 1, 'h000);
    chk("t3_neg0_q", int'(q_w[0]), 'h000);
    chk("t3_neg0_co", int'(co_w[0]), 1);
    step(1, 0, 0, 1, 'h800);
    chk("t3_min_ov", int'(ov_w[0]), 1);
    chk("t3_min_q_wrap", int'(q_w[0]), 'h800);
    chk("t3_min_q_sat", int'(q_w[1]), 'h7FF);

    step(0, 0, 0, 0, 0, 1);
    chk("sclr_ovs", int'({ovs_w[0], ovs_w[1]}), 0);
    chk("sclr_q", int'(q_w[0]), 0);

    // 4: overflow on accumulate, clamp both ways, sticky flag
    step(1, 0, 0, 0, 'h7FF);
    step(1, 0, 0, 0, 'h800);
    step(1, 1, 1, 0, 1);
    chk("t4_pos_q_wrap", int'(q_w[0]), 'h800);
    chk("t4_pos_q_sat", int'(q_w[1]), 'h7FF);
    chk("t4_pos_ov", int'({ov_w[0], ov_w[1]}), 3);
    chk("t4_ovs", int'(ovs_w[0]), 1);
    step(1, 0, 1, 1, 1);
    chk("t4_neg_q_sat", int'(q_w[1]), 'h800);
    chk("t4_neg_q_wrap", int'(q_w[0]), 'h7FF);
    step(1, 0, 0, 0, 5);
    chk("t4_clean_ov", int'(ov_w[0]), 0);
    chk("t4_sticky", int'({ovs_w[0], ovs_w[1]}), 3);

    // 5: CH_SYNC realign, SCLR with a sample
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 5);
    chk("t5_sync_och", int'(och_w[0]), 0);
    chk("t5_sync_q", int'(q_w[0]), 5);
    step(1, 0, 0, 0, 6);
    chk("t5_next_och", int'(och_w[0]), 1);
    step(1, 0, 0, 0, 9, 1);
    chk("t5_sclr_vld", int'(vld_w[0]), 0);
    chk("t5_sclr_ovs", int'(ovs_w[0]), 0);
    chk("t5_sclr_q", int'(q_w[0]), 0);
    step(1, 0, 1, 0, 7);
    chk("t5_after_q", int'(q_w[0]), 7);
    chk("t5_after_och", int'(och_w[0]), 0);

    // 6: async reset mid-cycle, gaps hold the pointer
    step(1, 0, 0, 0, 'h21);
    step(1, 0, 0, 0, 'h22);
    step(1, 0, 0, 0, 'h23);
    #1 rst = 1;
    #1;
    chk("t6_rst_q", int'(q_w[0]), 0);
    chk("t6_rst_vld", int'(vld_w[0]), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 0;
    step(1, 0, 1, 0, 3);
    chk("t6_first_och", int'(och_w[0]), 0);
    chk("t6_first_q", int'(q_w[0]), 3);
    idle(3);
    step(1, 0, 1, 0, 4);
    chk("t6_gap_och", int'(och_w[0]), 1);
    chk("t6_gap_q", int'(q_w[0]), 4);
    idle(3);
    step(1, 0, 1, 1, 2);
    chk("t6_gap2_och", int'(och_w[0]), 2);
    chk("t6_gap2_q", int'(q_w[0]), 'hFFE);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
